// File: rtl/mask_exp_gen_p_pkg.sv
// Shared constants, FSM encoding and operand-size helper for the exponent
// masking controller.
package mask_exp_pkg;

  localparam logic [1:0] MODE_4096 = 2'd0;
  localparam logic [1:0] MODE_2048 = 2'd1;
  localparam logic [1:0] MODE_1024 = 2'd2;
  localparam logic [1:0] MODE_512  = 2'd3;

  localparam logic [15:0] LFSR_TAPS_DEF = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_R, S_RUN, S_FLUSH, S_DONE
  } state_e;

  function automatic int unsigned n_words(input logic [1:0] mode, input int unsigned max_words);
    return max_words >> mode;
  endfunction

endpackage

// File: rtl/mask_exp_gen_p_if.sv
// Word streams of the masking controller: phi(N) and E in, E' out.
interface mask_exp_gen_p_if #(parameter int WORD_W = 32);
  logic              phi_valid;
  logic [WORD_W-1:0] phi_data;
  logic              phi_ready;
  logic              ei_valid;
  logic [WORD_W-1:0] ei_data;
  logic              ei_ready;
  logic              exp_valid;
  logic [WORD_W-1:0] exp_data;
  logic              exp_ready;

  modport master (output phi_valid, phi_data, ei_valid, ei_data, exp_ready,
                  input  phi_ready, ei_ready, exp_valid, exp_data);
  modport slave  (input  phi_valid, phi_data, ei_valid, ei_data, exp_ready,
                  output phi_ready, ei_ready, exp_valid, exp_data);
endinterface

// File: rtl/lfsr_random_gen_p.sv
// Right-shifting Galois LFSR; a zero seed is forced to 1 to avoid lockup.
module lfsr_random_gen_p
  import mask_exp_pkg::*;
#(
  parameter int           W    = 16,
  parameter logic [W-1:0] TAPS = LFSR_TAPS_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         adv,
  output logic [W-1:0] state
);

  logic [W-1:0] nxt;
  assign nxt = state[0] ? ((state >> 1) ^ TAPS) : (state >> 1);

  always_ff @(posedge clk) begin
    if (rst)       state <= W'(1);
    else if (load) state <= (seed == '0) ? W'(1) : seed;
    else if (adv)  state <= nxt;
  end

endmodule

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; rdata reads 0 while empty.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 129,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     rdata,
  output logic             empty,
  output logic             full,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/mask_exp_gen_p.sv
// Exponent blinding: streams E' = E + r*phi(N) word-serially, LSW first,
// with r drawn once per operation from the LFSR, into a FWFT output FIFO.
module mask_exp_gen_p
  import mask_exp_pkg::*;
#(
  parameter int                WORD_W    = 32,
  parameter int                RAND_W    = 16,
  parameter int                MAX_WORDS = 128,
  parameter logic [RAND_W-1:0] LFSR_TAPS = LFSR_TAPS_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     mode,
  input  logic                           start,
  input  logic [RAND_W-1:0]              seed,
  input  logic                           seed_load,
  mask_exp_gen_p_if.slave                st,
  output logic                           exp_full,
  output logic [$clog2(MAX_WORDS+2)-1:0] fifo_level,
  output logic                           busy,
  output logic                           done
);

  localparam int DEPTH = MAX_WORDS + 1;
  localparam int LVL_W = $clog2(MAX_WORDS + 2);
  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam int SUM_W = WORD_W + RAND_W;

  state_e              state, state_nx;
  logic [1:0]          mode_q;
  logic [CNT_W-1:0]    n_q, cnt;
  logic [RAND_W-1:0]   r_q, carry, lfsr_st;
  logic                s1_vld;
  logic [SUM_W-1:0]    s1_sum, sum2;
  logic                room, fire, push, pop, full, empty;
  logic [WORD_W-1:0]   wdata;

  assign n_q  = CNT_W'(n_words(mode_q, MAX_WORDS));
  assign sum2 = s1_sum + SUM_W'(carry);

  // Admission counts the word still in the product stage, so its push can never meet a full FIFO.
  assign room = ({1'b0, fifo_level} + (LVL_W+1)'(s1_vld)) < (LVL_W+1)'(DEPTH);
  assign st.phi_ready = (state == S_RUN) & st.phi_valid & st.ei_valid & room;
  assign st.ei_ready  = st.phi_ready;
  assign fire = st.phi_ready;
  assign pop  = st.exp_valid & st.exp_ready;
  assign st.exp_valid = ~empty;
  assign busy = (state == S_LOAD_R) || (state == S_RUN) || (state == S_FLUSH);
  assign done = (state == S_DONE);

  always_comb begin
    push  = 1'b0;
    wdata = '0;
    if (s1_vld) begin
      push  = 1'b1;
      wdata = sum2[WORD_W-1:0];
    end else if (state == S_FLUSH && !full) begin
      push  = 1'b1;
      wdata = {{(WORD_W-RAND_W){1'b0}}, carry};
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_LOAD_R;
      S_LOAD_R: state_nx = S_RUN;
      S_RUN:    if (fire && cnt == n_q - CNT_W'(1)) state_nx = S_FLUSH;
      S_FLUSH:  if (!s1_vld && !full) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      mode_q   <= '0;
      cnt      <= '0;
      r_q      <= '0;
      carry    <= '0;
      s1_vld   <= 1'b0;
      s1_sum   <= '0;
      exp_full <= 1'b0;
    end else begin
      state  <= state_nx;
      s1_vld <= fire;
      if (state == S_IDLE && start) begin
        mode_q <= mode;
        cnt    <= '0;
      end
      if (state == S_LOAD_R) r_q <= lfsr_st;
      if (fire) begin
        cnt    <= cnt + CNT_W'(1);
        s1_sum <= SUM_W'(st.ei_data) + SUM_W'(r_q) * SUM_W'(st.phi_data);
      end
      if (state == S_DONE) carry <= '0;
      else if (s1_vld)     carry <= sum2[SUM_W-1:WORD_W];
      if (pop)                                        exp_full <= 1'b0;
      else if (push && 32'(fifo_level) == 32'(n_q))   exp_full <= 1'b1;
    end
  end

  lfsr_random_gen_p #(.W(RAND_W), .TAPS(LFSR_TAPS)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (seed_load),
    .seed  (seed),
    .adv   (state == S_LOAD_R),
    .state (lfsr_st)
  );

  sync_fifo #(.W(WORD_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (st.exp_data),
    .empty (empty),
    .full  (full),
    .level (fifo_level)
  );

endmodule

// File: doc/mask_exp_gen_p.md
Name: mask_exp_gen_p

Overview:
Parametrised successor to the exponent-masking controller. It streams the Euler function phi(N) and the source exponent E word-serially, LSW first. It computes the blinded exponent E' = E + r*phi(N) with a random mask r drawn from an internal LFSR, and buffers the result, including a final carry word, in an output FIFO for the modular-exponentiation datapath. Inputs and outputs use valid/ready handshakes. A per-operation start/busy/done protocol replaces the earlier free-running full-flag enable.

Parameters:
WORD_W, 32, datapath word width in bits
RAND_W, 16, mask width; also the LFSR width and the carry width
MAX_WORDS, 128, operand words in mode 00 (4096-bit at WORD_W=32)
LFSR_TAPS, 16'hB400, Galois feedback polynomial (RAND_W bits)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
mode  in  2  operand size; N = MAX_WORDS>>mode words (128/64/32/16)
start  in  1  one-cycle request to begin an operation
seed  in  RAND_W  LFSR seed
seed_load  in  1  load seed into the LFSR
phi_valid / phi_data / phi_ready  in / in / out  1 / WORD_W / 1  phi(N) word stream
ei_valid / ei_data / ei_ready  in / in / out  1 / WORD_W / 1  E word stream
exp_valid / exp_data / exp_ready  out / out / in  1 / WORD_W / 1  E' word stream
exp_full  out  1  complete result (N+1 words) present in FIFO
fifo_level  out  $clog2(MAX_WORDS+2)  FIFO occupancy
busy  out  1  operation in progress
done  out  1  one-cycle pulse when the last word is written

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM goes to IDLE; FIFO empties; carry=0; word counter=0.
  - LFSR state=1.
  - All outputs are 0: phi_ready, ei_ready, exp_valid, exp_full, busy, done, fifo_level=0, exp_data=0.
  - Reset applies mid-operation with no partial result retained.
- LFSR:
  - seed_load=1 loads seed, with 0 replaced by 1 because all-zero is a lockup state.
  - seed_load has priority over the LFSR advance.
  - Otherwise the LFSR advances exactly once per operation, in the LOAD_R state.
- FSM states: IDLE, LOAD_R, RUN, FLUSH, DONE.
- IDLE:
  - On start=1, latch mode into mode_q and compute N. Go to LOAD_R; busy=1 from the next cycle.
  - start while busy is ignored. mode changes after latching are ignored.
- LOAD_R (1 cycle): r_q <= current LFSR state, then the LFSR advances. Go to RUN.
- RUN:
  - phi_ready = ei_ready = (both valids high) & FIFO not full. A word pair is consumed only when both handshakes fire in the same cycle. If either valid is low, the FSM stalls with no write.
  - Per pair: sum[WORD_W+RAND_W-1:0] = ei + r_q*phi + carry. Write sum[WORD_W-1:0] to the FIFO; carry <= sum[WORD_W+RAND_W-1:WORD_W]. The sum cannot overflow: maximum is 2^(W+R)-1.
  - After the N-th pair, go to FLUSH.
- FLUSH: when FIFO not full, write {zero-extended carry} as word N. Go to DONE.
- DONE: done=1 for 1 cycle, busy=0, carry cleared. Go to IDLE.
- Latency: first E' word is visible on exp_valid 2 cycles after the first accepted pair.
- FIFO:
  - Depth MAX_WORDS+1 (holds one full mode-00 result); first-word-fall-through.
  - exp_valid = !empty. Pop on exp_valid & exp_ready; exp_ready while empty has no effect.
  - A simultaneous push and pop leaves fifo_level unchanged.
  - Full blocks the push; the FSM stalls in RUN or FLUSH and never overflows.
- exp_full: set when fifo_level reaches N_q+1 with no pop that cycle; cleared on the first pop; cleared on rst.

Decomposition:
- Package mask_exp_pkg:
  - mode constants MODE_4096..MODE_512.
  - function n_words(mode, MAX_WORDS).
  - FSM state enum.
  - default LFSR_TAPS.
- Sub-modules:
  - lfsr_random_gen_p (parametrised Galois LFSR with load and advance enable).
  - The existing sync_fifo, reused for the output buffer.

Test Plan:
1. seed_load 0x0003, mode=11, start; 16 pairs of phi=0xFFFFFFFF, ei=0 -> E' words: 0xFFFFFFFD, 15x 0xFFFFFFFF, top 0x00000002. done pulses once; exp_full=1 at fifo_level=17.
2. seed_load 0x0000, mode=11; phi word k = k, ei word k = 0x100 -> r=1, output word k = k+0x100, top word 0.
3. mode=00, seed 0x1234; drop phi_valid for 5 cycles at word 40 -> no FIFO writes during the gap. Result matches reference model E+0x1234*phi (129 words) with exp_ready held 0 throughout; no overflow.
4. start pulsed again and mode toggled during RUN -> ignored; word count stays N_q; only one done pulse.
5. rst asserted after word 5 of a mode-01 op -> next cycle all outputs 0 and fifo_level=0. A following op with seed 0x0003 matches test-1 style expected values.
6. Back-to-back: pop continuously during RUN -> fifo_level stays constant on simultaneous push/pop. A second start after done uses the advanced LFSR state as r.
